shift_rows_pipe: RTL



---
 rtl/shift_rows_pipe.sv | 107 ++++++++++
 1 files changed

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined ShiftRows / InvShiftRows for Rijndael states of NB columns.
// The byte permutation sits in front of stage 0; later stages are elastic registers.
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [32*NB-1:0]   in_data,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);
    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be in 1..4");
    end

    // Rijndael row offsets: wide (NB = 8) blocks skip 2 in rows 2 and 3.
    function automatic int row_shift(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic int src_col(input int r, input int c, input logic inv);
        return inv ? (c + NB - row_shift(r)) % NB : (c + row_shift(r)) % NB;
    endfunction

    logic [W-1:0]      xf;
    logic [STAGES-1:0] v_q;
    logic [W-1:0]      data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] src_v;
    logic [W-1:0]      src_data [STAGES];
    logic [TAG_W-1:0]  src_tag  [STAGES];

    always_comb begin
        xf = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NB; c++) begin
                xf[W-1-8*(r+4*c) -: 8] = in_data[W-1-8*(r+4*src_col(r, c, in_inv)) -: 8];
            end
        end
    end

    // A stage can load if empty or if its content leaves this same cycle.
    always_comb begin
        ld = '0;
        ld[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            ld[i] = !v_q[i] || ld[i+1];
        end
    end

    always_comb begin
        src_v       = '0;
        src_v[0]    = in_valid;
        src_data[0] = xf;
        src_tag[0]  = in_tag;
        for (int i = 1; i < STAGES; i++) begin
            src_v[i]    = v_q[i-1];
            src_data[i] = data_q[i-1];
            src_tag[i]  = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (flush) begin
            v_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (ld[i]) begin
                    v_q[i] <= src_v[i];
                    if (src_v[i]) begin
                        data_q[i] <= src_data[i];
                        tag_q[i]  <= src_tag[i];
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0] || flush;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign busy      = |v_q;

endmodule
